// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type, word width and mode helper for the SPI slave
package spi_pkg;

    localparam int SPI_WORD_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } spi_state_e;

    // cpha=0 samples on the leading sclk edge, cpha=1 on the trailing one.
    function automatic logic mode_sample_on_lead(input logic cpha);
        return ~cpha;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage synchroniser with optional rise/fall pulse detection
module spi_sync_edge #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0,
    parameter bit EDGE_DET  = 1'b1
) (
    input  logic clk,
    input  logic arst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign dout = sync_q[STAGES-1];

    generate
        if (EDGE_DET) begin : g_edge
            logic hist_q;

            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    hist_q <= RESET_VAL;
                end else begin
                    hist_q <= dout;
                end
            end

            assign rise = dout & ~hist_q;
            assign fall = ~dout & hist_q;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_slave_rx_tx.sv
// rtl/spi_slave_rx_tx.sv - oversampled SPI slave, all cpol/cpha modes, LSB-first words
module spi_slave_rx_tx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_WORD_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    spi_state_e         state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  rx_shift;
    logic [DATA_W-1:0]  tx_shift;
    logic               reload;

    logic sclk_norm;
    logic sclk_lvl;
    logic lead_edge;
    logic trail_edge;
    logic cs_lvl;
    logic cs_rise;
    logic cs_fall;
    logic mosi_s;
    logic mosi_rise_unused;
    logic mosi_fall_unused;
    logic sample_on_lead;
    logic sample_edge;
    logic shift_edge;

    // sclk is folded with cpol so the synchroniser idles at 0 in every mode.
    assign sclk_norm = sclk ^ cpol;

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0),
        .EDGE_DET  (1'b1)
    ) u_sclk_sync (
        .clk  (clk),
        .arst (arst),
        .din  (sclk_norm),
        .dout (sclk_lvl),
        .rise (lead_edge),
        .fall (trail_edge)
    );

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1),
        .EDGE_DET  (1'b1)
    ) u_cs_sync (
        .clk  (clk),
        .arst (arst),
        .din  (cs),
        .dout (cs_lvl),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0),
        .EDGE_DET  (1'b0)
    ) u_mosi_sync (
        .clk  (clk),
        .arst (arst),
        .din  (mosi),
        .dout (mosi_s),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    assign sample_on_lead = mode_sample_on_lead(cpha);
    assign sample_edge    = sample_on_lead ? lead_edge  : trail_edge;
    assign shift_edge     = sample_on_lead ? trail_edge : lead_edge;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            reload    <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            tx_load   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            tx_load   <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall && !cs_lvl) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    tx_shift <= tx_data;
                    tx_load  <= 1'b1;
                    bit_cnt  <= '0;
                    reload   <= 1'b0;
                    if (cs_rise) begin
                        state   <= IDLE;
                        miso_oe <= 1'b0;
                        miso    <= 1'b0;
                    end else begin
                        state   <= ACTIVE;
                        miso_oe <= 1'b1;
                        miso    <= sample_on_lead ? tx_data[0] : 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state   <= IDLE;
                        miso_oe <= 1'b0;
                        miso    <= 1'b0;
                        bit_cnt <= '0;
                        reload  <= 1'b0;
                        // A word whose last bit coincides with deselect still completes.
                        if (bit_cnt == CNT_FULL) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                        end else if (sample_edge && bit_cnt == CNT_LAST) begin
                            rx_data  <= {mosi_s, rx_shift[DATA_W-1:1]};
                            rx_valid <= 1'b1;
                        end else if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                    end else if (bit_cnt == CNT_FULL) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        tx_shift <= tx_data;
                        tx_load  <= 1'b1;
                        reload   <= sample_on_lead;
                    end else if (sample_edge) begin
                        rx_shift <= {mosi_s, rx_shift[DATA_W-1:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                    end else if (shift_edge) begin
                        // cpha=0 already shows bit0, so its shift edges present the next bit.
                        if (reload) begin
                            miso   <= tx_shift[0];
                            reload <= 1'b0;
                        end else if (sample_on_lead) begin
                            miso     <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                        end else begin
                            miso     <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
